egress_interface: RTL and testbench

EGRESS_INTERFACE -- requirements
Module: egress_interface

---
 rtl/egress_interface.sv | 210 +++++++++++++++++++++
 tb/tb_egress_interface.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/egress_interface.sv
// Egress interface: turns one command packet plus its data beats from the layer
// engine into a single SAP master write, then returns a status packet.
`ifndef NIF_MASTER_CMD_WRREQ
`define NIF_MASTER_CMD_WRREQ 4'h1
`endif

module egress_interface #(
  parameter int C_PACKET_WIDTH = 128,
  parameter int C_FIFO_DEPTH   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ext_input_valid,
  output logic                      ext_input_accept,
  input  logic [C_PACKET_WIDTH-1:0] ext_input_payload,
  output logic                      ext_output_valid,
  input  logic                      ext_output_accept,
  output logic [C_PACKET_WIDTH-1:0] ext_output_payload,
  output logic                      master_request,
  input  logic                      master_request_ack,
  input  logic                      master_request_complete,
  input  logic [6:0]                master_request_error,
  output logic [3:0]                master_request_type,
  output logic [63:0]               master_request_local_address,
  output logic [35:0]               master_request_length,
  output logic                      master_dataout_src_rdy,
  input  logic                      master_dataout_dst_rdy,
  output logic [127:0]              master_dataout
);

  // state     | meaning
  // IDLE      | waiting for a command packet
  // REQUEST   | master_request held until ack; data intake open
  // STREAM    | FIFO drains onto the write-data stream
  // WAIT_DONE | all beats sent, waiting for completion
  // RESPOND   | status packet offered until accepted
  typedef enum logic [4:0] {
    S_IDLE      = 5'b00001,
    S_REQUEST   = 5'b00010,
    S_STREAM    = 5'b00100,
    S_WAIT_DONE = 5'b01000,
    S_RESPOND   = 5'b10000
  } state_t;

  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  state_t       state, state_nxt;
  logic [63:0]  addr_q;
  logic [35:0]  len_q;
  logic [32:0]  beat_cnt_q, beats_in_q, beats_out_q;
  logic         sticky_q;
  logic [6:0]   sticky_err_q;
  logic         err_flag_q;
  logic [6:0]   err_code_q;
  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic [127:0] fifo_mem [C_FIFO_DEPTH];

  logic [63:0]  cmd_addr;
  logic [35:0]  cmd_len;
  logic [36:0]  cmd_len_rnd;
  logic         fifo_empty, fifo_full;
  logic         accept_int, req_int, src_rdy_int, out_valid_int;
  logic         push, pop;
  logic [6:0]   done_err;

  assign cmd_addr    = ext_input_payload[127:64];
  assign cmd_len     = ext_input_payload[63:28];
  assign cmd_len_rnd = {1'b0, cmd_len} + 37'd15;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // a sticky completion from REQUEST/STREAM takes priority over a live one
  assign done_err = sticky_q ? sticky_err_q : master_request_error;

  always_comb begin
    state_nxt     = state;
    accept_int    = 1'b0;
    req_int       = 1'b0;
    src_rdy_int   = 1'b0;
    out_valid_int = 1'b0;
    case (state)
      S_IDLE: begin
        accept_int = 1'b1;
        if (ext_input_valid)
          state_nxt = (cmd_len == 36'd0) ? S_RESPOND : S_REQUEST;
      end
      S_REQUEST: begin
        req_int    = 1'b1;
        accept_int = !fifo_full && (beats_in_q < beat_cnt_q);
        if (master_request_ack)
          state_nxt = S_STREAM;
      end
      S_STREAM: begin
        accept_int  = !fifo_full && (beats_in_q < beat_cnt_q);
        src_rdy_int = !fifo_empty;
        if (src_rdy_int && master_dataout_dst_rdy &&
            (beats_out_q + 33'd1 == beat_cnt_q))
          state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (master_request_complete || sticky_q)
          state_nxt = S_RESPOND;
      end
      S_RESPOND: begin
        out_valid_int = 1'b1;
        if (ext_output_accept)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign push = rst && ((state == S_REQUEST) || (state == S_STREAM)) &&
                ext_input_valid && accept_int;
  assign pop  = rst && src_rdy_int && master_dataout_dst_rdy;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      beat_cnt_q   <= '0;
      beats_in_q   <= '0;
      beats_out_q  <= '0;
      sticky_q     <= 1'b0;
      sticky_err_q <= '0;
      err_flag_q   <= 1'b0;
      err_code_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state <= state_nxt;
      if (push) begin
        wr_ptr_q   <= wr_ptr_q + PTR_ONE;
        beats_in_q <= beats_in_q + 33'd1;
      end
      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + PTR_ONE;
        beats_out_q <= beats_out_q + 33'd1;
      end
      case (state)
        S_IDLE: begin
          if (ext_input_valid) begin
            addr_q     <= cmd_addr;
            len_q      <= cmd_len;
            beat_cnt_q <= cmd_len_rnd[36:4];
            err_flag_q <= (cmd_len == 36'd0);
            err_code_q <= (cmd_len == 36'd0) ? 7'h7F : 7'h00;
          end
        end
        S_REQUEST, S_STREAM: begin
          if (master_request_complete && !sticky_q) begin
            sticky_q     <= 1'b1;
            sticky_err_q <= master_request_error;
          end
        end
        S_WAIT_DONE: begin
          if (master_request_complete || sticky_q) begin
            err_code_q <= done_err;
            err_flag_q <= (done_err != 7'd0);
          end
        end
        S_RESPOND: begin
          if (ext_output_accept) begin
            beats_in_q  <= '0;
            beats_out_q <= '0;
            sticky_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr_q[AW-1:0]] <= ext_input_payload[127:0];
  end

  // every output is forced low while reset is held
  assign ext_input_accept             = rst && accept_int;
  assign master_request               = rst && req_int;
  assign master_dataout_src_rdy       = rst && src_rdy_int;
  assign ext_output_valid             = rst && out_valid_int;
  assign master_request_type          = (rst && req_int) ? `NIF_MASTER_CMD_WRREQ : 4'd0;
  assign master_request_local_address = (rst && req_int) ? addr_q : 64'd0;
  assign master_request_length        = (rst && req_int) ? len_q : 36'd0;
  assign master_dataout               = (rst && (state == S_STREAM)) ?
                                        fifo_mem[rd_ptr_q[AW-1:0]] : 128'd0;

  always_comb begin
    ext_output_payload = '0;
    if (rst && out_valid_int)
      ext_output_payload[127:0] = {addr_q, len_q, 20'd0, err_flag_q, err_code_q};
  end

  logic unused_bits;
  assign unused_bits = ^{ext_input_payload[27:0], cmd_len_rnd[3:0]};

  if (C_PACKET_WIDTH > 128) begin : g_wide
    logic unused_upper;
    assign unused_upper = ^ext_input_payload[C_PACKET_WIDTH-1:128];
  end

endmodule

// File: tb/tb_egress_interface.sv
// Randomized bench for egress_interface: a source, a SAP master model and a
// response sink run concurrently against a transaction-level expectation.
`ifndef NIF_MASTER_CMD_WRREQ
`define NIF_MASTER_CMD_WRREQ 4'h1
`endif

module tb_egress_interface;
  localparam int PW    = 128;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ext_input_valid;
  logic          ext_input_accept;
  logic [PW-1:0] ext_input_payload;
  logic          ext_output_valid;
  logic          ext_output_accept;
  logic [PW-1:0] ext_output_payload;
  logic          master_request;
  logic          master_request_ack;
  logic          master_request_complete;
  logic [6:0]    master_request_error;
  logic [3:0]    master_request_type;
  logic [63:0]   master_request_local_address;
  logic [35:0]   master_request_length;
  logic          master_dataout_src_rdy;
  logic          master_dataout_dst_rdy;
  logic [127:0]  master_dataout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  egress_interface #(.C_PACKET_WIDTH(PW), .C_FIFO_DEPTH(DEPTH)) dut (
    .clk                          (clk),
    .rst                          (rst),
    .ext_input_valid              (ext_input_valid),
    .ext_input_accept             (ext_input_accept),
    .ext_input_payload            (ext_input_payload),
    .ext_output_valid             (ext_output_valid),
    .ext_output_accept            (ext_output_accept),
    .ext_output_payload           (ext_output_payload),
    .master_request               (master_request),
    .master_request_ack           (master_request_ack),
    .master_request_complete      (master_request_complete),
    .master_request_error         (master_request_error),
    .master_request_type          (master_request_type),
    .master_request_local_address (master_request_local_address),
    .master_request_length        (master_request_length),
    .master_dataout_src_rdy       (master_dataout_src_rdy),
    .master_dataout_dst_rdy       (master_dataout_dst_rdy),
    .master_dataout               (master_dataout)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {ext_input_accept, ext_output_valid, master_request, master_dataout_src_rdy}, 0);
    chk({tag, "_data"}, |{ext_output_payload, master_dataout, master_request_local_address,
                          master_request_length, master_request_type}, 0);
  endtask

  task automatic run_txn(input logic [63:0] addr, input logic [35:0] len, input int ack_delay,
                         input int prob, input int stall, input logic [6:0] err,
                         input bit early, input int extra);
    logic [127:0] exp_q[$];
    logic [127:0] cmd, exp_resp;
    longint       n_beats;
    int           beats_acc, pops;
    bit           src_done, resp_done;
    logic [6:0]   exp_code;
    logic         exp_flag;
    n_beats   = (longint'(len) + 15) / 16;
    exp_code  = (len == 0) ? 7'h7F : err;
    exp_flag  = (len == 0) || (err != 7'd0);
    exp_resp  = {addr, len, 20'h0, exp_flag, exp_code};
    cmd       = {addr, len, 28'h0};
    cmd[27:0] = 28'($urandom);
    beats_acc = 0;
    pops      = 0;
    src_done  = 0;
    resp_done = 0;
    fork
      begin
        bit ok;
        ok = 0;
        for (int c = 0; c < 200 && !ok; c++) begin
          @(negedge clk);
          ext_input_valid   = 1'b1;
          ext_input_payload = cmd;
          #1;
          ok = ext_input_accept;
        end
        chk("cmd_accepted", ok, 1);
        for (longint i = 0; i < n_beats && ok; i++) begin
          logic [127:0] d;
          d  = rand128();
          ok = 0;
          for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge clk);
            ext_input_valid   = 1'b1;
            ext_input_payload = d;
            #1;
            ok = ext_input_accept;
          end
          chk("beat_accepted", ok, 1);
          if (ok) begin
            exp_q.push_back(d);
            beats_acc++;
          end
        end
        for (int e = 0; e < extra; e++) begin
          @(negedge clk);
          ext_input_valid   = 1'b1;
          ext_input_payload = rand128();
          #1;
          chk("extra_beat_blocked", ext_input_accept, 0);
        end
        @(negedge clk);
        ext_input_valid = 1'b0;
        src_done = 1;
      end
      begin
        int cyc, req_wait, n_req;
        bit ack_now, cmpl_now, cmpl_done;
        cyc = 0; req_wait = 0; n_req = 0;
        ack_now = 0; cmpl_now = 0; cmpl_done = 0;
        while (!resp_done && cyc < 5000) begin
          bit ack_nx, cmpl_nx;
          @(negedge clk);
          master_request_ack      = ack_now;
          master_request_complete = cmpl_now;
          master_request_error    = cmpl_now ? err : 7'h0;
          master_dataout_dst_rdy  = (cyc >= stall) && ($urandom_range(99) < prob);
          #1;
          ack_nx  = 0;
          cmpl_nx = 0;
          if (master_request) begin
            chk("req_addr", master_request_local_address, addr);
            chk("req_len", master_request_length, len);
            chk("req_type", master_request_type, `NIF_MASTER_CMD_WRREQ);
            if (ack_now) n_req++;
            else begin
              req_wait++;
              ack_nx = (req_wait >= ack_delay);
            end
          end
          if (master_dataout_src_rdy && master_dataout_dst_rdy) begin
            chk("beat_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("beat_data", master_dataout, exp_q.pop_front());
            pops++;
          end
          if (!cmpl_done && len != 0 && ((early && pops >= 1) || pops == n_beats)) begin
            cmpl_nx   = 1;
            cmpl_done = 1;
          end
          if (stall >= 30 && cyc == stall - 1) begin
            #1;
            chk("fifo_fill_stalled", beats_acc, (n_beats < DEPTH) ? n_beats : DEPTH);
          end
          ack_now  = ack_nx;
          cmpl_now = cmpl_nx;
          cyc++;
        end
        chk("master_done", resp_done, 1);
        master_request_ack      = 1'b0;
        master_request_complete = 1'b0;
        master_request_error    = 7'h0;
        master_dataout_dst_rdy  = 1'b0;
        chk("request_count", n_req, (len != 0) ? 1 : 0);
      end
      begin
        bit seen, sdone;
        seen = 0;
        for (int c = 0; c < 5000 && !seen; c++) begin
          @(negedge clk);
          #1;
          seen = ext_output_valid;
        end
        chk("resp_seen", seen, 1);
        chk("resp_payload", ext_output_payload, exp_resp);
        sdone = src_done;
        for (int c = 0; c < 5000 && !sdone; c++) begin
          @(negedge clk);
          #1;
          sdone = src_done;
        end
        chk("resp_hold", ext_output_payload, exp_resp);
        @(negedge clk);
        ext_output_accept = 1'b1;
        #1;
        chk("resp_valid_held", ext_output_valid, 1);
        @(negedge clk);
        ext_output_accept = 1'b0;
        #1;
        chk("resp_cleared", ext_output_valid, 0);
        chk("idle_accept", ext_input_accept, 1);
        resp_done = 1;
      end
    join
    chk("beats_accepted_total", beats_acc, n_beats);
    chk("beats_sent_total", pops, n_beats);
  endtask

  initial begin
    ext_input_valid         = 1'b0;
    ext_input_payload       = '0;
    ext_output_accept       = 1'b0;
    master_request_ack      = 1'b0;
    master_request_complete = 1'b0;
    master_request_error    = 7'h0;
    master_dataout_dst_rdy  = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("accept_after_reset", ext_input_accept, 1);
    chk("src_rdy_after_reset", master_dataout_src_rdy, 0);

    run_txn(64'h1000, 36'd64, 3, 100, 0, 7'h00, 1'b0, 0);
    run_txn({$urandom, $urandom}, 36'd20, 1, 100, 0, 7'h00, 1'b0, 3);
    run_txn({$urandom, $urandom}, 36'd0, 0, 100, 0, 7'h00, 1'b0, 0);
    run_txn({$urandom, $urandom}, 36'd512, 3, 100, 40, 7'h00, 1'b0, 0);
    run_txn({$urandom, $urandom}, 36'd64, 2, 50, 0, 7'h05, 1'b1, 0);

    // abort a transaction mid-STREAM
    master_request_ack     = 1'b1;
    master_dataout_dst_rdy = 1'b1;
    @(negedge clk);
    ext_input_valid   = 1'b1;
    ext_input_payload = {64'h2000, 36'd64, 28'h0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ext_input_payload = rand128();
    end
    #1;
    chk("mid_stream_src_rdy", master_dataout_src_rdy, 1);
    @(negedge clk);
    rst = 1'b0;
    ext_input_valid = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    @(negedge clk);
    #1;
    chk_all_zero("mid_rst_hold");
    @(negedge clk);
    rst = 1'b1;
    master_request_ack     = 1'b0;
    master_dataout_dst_rdy = 1'b0;
    #1;
    chk("post_abort_accept", ext_input_accept, 1);
    chk("post_abort_ctl", {master_dataout_src_rdy, master_request, ext_output_valid}, 0);
    run_txn(64'h3000, 36'd48, 2, 100, 0, 7'h00, 1'b0, 0);

    for (int t = 0; t < 12; t++) begin
      logic [35:0] len;
      logic [6:0]  err;
      int          r;
      r = $urandom_range(9);
      if (r == 0)      len = 36'd0;
      else if (r == 1) len = 36'(16 * $urandom_range(1, 8));
      else             len = 36'($urandom_range(1, 200));
      err = ($urandom_range(2) == 0) ? 7'($urandom_range(1, 127)) : 7'h00;
      run_txn({$urandom, $urandom}, len, $urandom_range(0, 5), $urandom_range(30, 100), 0,
              err, 1'($urandom_range(1)), $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
